tcu_fedp_arbiter: RTL and testbench

Shares one fixed-latency TCU dot-product (FEDP) pipeline between `NUM_REQS` requesters. Each cycle it grants at most one request round-robin and drives the FEDP operand and format inputs from the winner. It tracks each issued operation's requester index and tag alongside the FEDP pipeline, then returns the `d_val` result through a registered valid/ready response port. It stalls the whole FEDP pipeline through its `enable` input when the response register cannot accept a result. It sits between the per-warp TCU operand collectors and the `VX_tcu_fedp_*` instance.

---
 rtl/tcu_fedp_arbiter.sv | 132 +++++++++++++
 tb/tb_tcu_fedp_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tcu_fedp_arbiter.sv
// Round-robin front end sharing one fixed-latency FEDP pipeline between NUM_REQS requesters.
// Tracks {valid, idx, tag} beside the FEDP and returns results through a registered valid/ready port.
module tcu_fedp_arbiter #(
    parameter int NUM_REQS  = 4,
    parameter int N         = 4,
    parameter int LATENCY   = 8,
    parameter int TAG_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQS-1:0]                  req_valid,
    output logic [NUM_REQS-1:0]                  req_ready,
    input  logic [NUM_REQS-1:0][3:0]             req_fmt_s,
    input  logic [NUM_REQS-1:0][3:0]             req_fmt_d,
    input  logic [NUM_REQS-1:0][N*32-1:0]        req_a_row,
    input  logic [NUM_REQS-1:0][N*32-1:0]        req_b_col,
    input  logic [NUM_REQS-1:0][31:0]            req_c_val,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]   req_tag,
    output logic                                 fedp_enable,
    output logic [3:0]                           fedp_fmt_s,
    output logic [3:0]                           fedp_fmt_d,
    output logic [N*32-1:0]                      fedp_a_row,
    output logic [N*32-1:0]                      fedp_b_col,
    output logic [31:0]                          fedp_c_val,
    input  logic [31:0]                          fedp_d_val,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [31:0]                          rsp_d_val,
    output logic [$clog2(NUM_REQS)-1:0]          rsp_idx,
    output logic [TAG_WIDTH-1:0]                 rsp_tag,
    output logic                                 busy
);

    localparam int IDX_W = $clog2(NUM_REQS);

    if (NUM_REQS < 2) begin : g_bad_num_reqs
        $error("tcu_fedp_arbiter: NUM_REQS must be >= 2");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("tcu_fedp_arbiter: LATENCY must be >= 1");
    end

    logic [IDX_W-1:0] rr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   cand;
    logic             any_valid;
    logic             fire;
    logic             tail_vld;

    logic [LATENCY-1:0]                vld_pipe;
    logic [LATENCY-1:0][IDX_W-1:0]     idx_pipe;
    logic [LATENCY-1:0][TAG_WIDTH-1:0] tag_pipe;

    // First valid requester scanning upward from rr, wrapping modulo NUM_REQS.
    always_comb begin
        grant_idx = rr;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand = {1'b0, rr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQS))
                cand = cand - (IDX_W+1)'(NUM_REQS);
            if (!any_valid && req_valid[cand[IDX_W-1:0]]) begin
                grant_idx = cand[IDX_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign tail_vld    = vld_pipe[LATENCY-1];
    // Freeze only when a finished result has nowhere to go.
    assign fedp_enable = !(tail_vld && rsp_valid && !rsp_ready);
    assign fire        = any_valid && fedp_enable;

    always_comb begin
        req_ready = '0;
        if (fire)
            req_ready[grant_idx] = 1'b1;
    end

    assign fedp_fmt_s = req_fmt_s[grant_idx];
    assign fedp_fmt_d = req_fmt_d[grant_idx];
    assign fedp_a_row = req_a_row[grant_idx];
    assign fedp_b_col = req_b_col[grant_idx];
    assign fedp_c_val = req_c_val[grant_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr       <= '0;
            vld_pipe <= '0;
        end else begin
            if (fire)
                rr <= (grant_idx == IDX_W'(NUM_REQS-1)) ? '0 : grant_idx + 1'b1;
            if (fedp_enable) begin
                vld_pipe[0] <= fire;
                for (int k = 1; k < LATENCY; k++)
                    vld_pipe[k] <= vld_pipe[k-1];
            end
        end
    end

    // Side-band payload is qualified by vld_pipe, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fedp_enable) begin
            idx_pipe[0] <= grant_idx;
            tag_pipe[0] <= req_tag[grant_idx];
            for (int k = 1; k < LATENCY; k++) begin
                idx_pipe[k] <= idx_pipe[k-1];
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_d_val <= '0;
            rsp_idx   <= '0;
            rsp_tag   <= '0;
        end else if (fedp_enable && tail_vld) begin
            rsp_valid <= 1'b1;
            rsp_d_val <= fedp_d_val;
            rsp_idx   <= idx_pipe[LATENCY-1];
            rsp_tag   <= tag_pipe[LATENCY-1];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign busy = (|vld_pipe) || rsp_valid;

endmodule

// File: tb/tb_tcu_fedp_arbiter.sv
// Directed bench for tcu_fedp_arbiter with a behavioural fixed-latency FEDP model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_tcu_fedp_arbiter;

    localparam int NR  = 4;
    localparam int N   = 4;
    localparam int LAT = 8;
    localparam int TW  = 4;
    localparam int W   = N*32;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0]           req_ready;
    logic [NR-1:0][3:0]      req_fmt_s, req_fmt_d;
    logic [NR-1:0][W-1:0]    req_a_row, req_b_col;
    logic [NR-1:0][31:0]     req_c_val;
    logic [NR-1:0][TW-1:0]   req_tag;
    logic                    fedp_enable;
    logic [3:0]              fedp_fmt_s, fedp_fmt_d;
    logic [W-1:0]            fedp_a_row, fedp_b_col;
    logic [31:0]             fedp_c_val, fedp_d_val;
    logic                    rsp_valid, rsp_ready;
    logic [31:0]             rsp_d_val;
    logic [1:0]              rsp_idx;
    logic [TW-1:0]           rsp_tag;
    logic                    busy;

    int n_chk  = 0;
    int n_fail = 0;

    tcu_fedp_arbiter #(.NUM_REQS(NR), .N(N), .LATENCY(LAT), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d),
        .req_a_row(req_a_row), .req_b_col(req_b_col),
        .req_c_val(req_c_val), .req_tag(req_tag),
        .fedp_enable(fedp_enable),
        .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d),
        .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col),
        .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_d_val(rsp_d_val), .rsp_idx(rsp_idx), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // FEDP stand-in: a LAT-deep enabled delay line of a simple operand mix.
    logic [LAT-1:0][31:0] mdl = '0;
    always @(posedge clk) begin
        if (fedp_enable) begin
            mdl[0] <= fedp_c_val ^ fedp_a_row[31:0] ^ fedp_b_col[W-1 -: 32] ^ {fedp_fmt_s, fedp_fmt_d, 24'h0};
            for (int k = 1; k < LAT; k++)
                mdl[k] <= mdl[k-1];
        end
    end
    assign fedp_d_val = mdl[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp4;
        logic       stale;

        req_valid = '0; req_fmt_s = '0; req_fmt_d = '0;
        req_a_row = '0; req_b_col = '0; req_c_val = '0; req_tag = '0;
        rsp_ready = 1'b1;
        reset     = 1'b0;

        nxt(); nxt();
        smp();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enable", fedp_enable, 1);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_data", {rsp_d_val, rsp_idx, rsp_tag}, 0);
        nxt(); reset = 1'b1;

        // Single request from req 2, tag 5
        nxt();
        req_valid = 4'b0100; req_tag[2] = 4'd5; req_c_val[2] = 32'h3F80_0000;
        smp();
        chk("single_grant", req_ready, 4'b0100);
        chk("single_mux_c", fedp_c_val, 32'h3F80_0000);
        stale = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            nxt();
            req_valid = '0;
            smp();
            stale |= rsp_valid;
            if (i == 1) chk("single_busy", busy, 1);
        end
        chk("single_no_early_rsp", stale, 0);
        nxt(); smp();
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_idx", rsp_idx, 2);
        chk("single_rsp_tag", rsp_tag, 5);
        chk("single_rsp_d", rsp_d_val, 32'h3F80_0000);
        nxt(); smp();
        chk("single_busy_fall", busy, 0);
        chk("single_rsp_clear", rsp_valid, 0);

        // Sparse: rr=3 now; req 3 alone is granted twice in a row across the wrap
        nxt();
        req_valid = 4'b1000; req_tag[3] = 4'd6; req_c_val[3] = 32'h4000_0000;
        req_fmt_s[3] = 4'h2; req_fmt_d[3] = 4'h1; req_b_col[3][W-1 -: 32] = 32'h0000_0010;
        smp();
        chk("sparse_grant0", req_ready, 4'b1000);
        chk("sparse_mux_fmt", {fedp_fmt_s, fedp_fmt_d}, 8'h21);
        nxt();
        req_tag[3] = 4'd7;
        smp();
        chk("sparse_grant_wrap", req_ready, 4'b1000);
        for (int c = 2; c <= 11; c++) begin
            nxt();
            req_valid = '0; req_fmt_s = '0; req_fmt_d = '0; req_b_col = '0;
            smp();
            if (c == 9 || c == 10) begin
                chk("sparse_rsp_valid", rsp_valid, 1);
                chk("sparse_rsp_idx", rsp_idx, 3);
                chk("sparse_rsp_tag", rsp_tag, (c == 9) ? 6 : 7);
                chk("sparse_rsp_d", rsp_d_val, 32'h6100_0010);
            end
        end
        chk("sparse_drained", rsp_valid, 0);

        // Fairness: all four valid for 8 cycles, rr=0
        for (int j = 0; j < NR; j++) begin
            req_c_val[j] = 32'h1000 + j;
            req_tag[j]   = TW'(j + 8);
        end
        for (int c = 0; c <= 17; c++) begin
            nxt();
            req_valid = (c < 8) ? 4'hF : 4'h0;
            smp();
            exp4 = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            chk("fair_grant", req_ready, exp4);
            if (c >= 9 && c <= 16) begin
                chk("fair_rsp_valid", rsp_valid, 1);
                chk("fair_rsp_idx", rsp_idx, (c - 9) % 4);
                chk("fair_rsp_tag", rsp_tag, ((c - 9) % 4) + 8);
                chk("fair_rsp_d", rsp_d_val, 32'h1000 + ((c - 9) % 4));
                chk("fair_no_stall", fedp_enable, 1);
            end
            if (c == 17) chk("fair_drained", rsp_valid, 0);
        end

        // Backpressure: req 0 streams while rsp_ready is low for 20 cycles
        req_tag[0] = 4'd3;
        for (int c = 0; c <= 30; c++) begin
            nxt();
            req_valid    = (c <= 20) ? 4'b0001 : 4'b0000;
            req_c_val[0] = 32'h2000 + ((c < 9) ? c : 9);
            rsp_ready    = (c >= 20);
            smp();
            chk("bp_enable", fedp_enable, !(c >= 9 && c <= 19));
            chk("bp_grant", req_ready, (c <= 20 && !(c >= 9 && c <= 19)) ? 4'b0001 : 4'b0000);
            chk("bp_rsp_valid", rsp_valid, (c >= 9 && c <= 29));
            if (c >= 9 && c <= 20) chk("bp_rsp_d_hold", rsp_d_val, 32'h2000);
            if (c >= 21 && c <= 29) begin
                chk("bp_rsp_d", rsp_d_val, 32'h2000 + (c - 20));
                chk("bp_rsp_tag", {rsp_idx, rsp_tag}, {2'd0, 4'd3});
            end
        end

        // Reset with five ops in flight from req 2
        for (int c = 0; c < 5; c++) begin
            nxt();
            req_valid = 4'b0100; req_c_val[2] = 32'h55;
            smp();
            chk("rstmf_grant", req_ready, 4'b0100);
        end
        nxt();
        req_valid = '0; reset = 1'b0;
        smp();
        chk("rstmf_busy_before", busy, 1);
        nxt();
        reset = 1'b1;
        smp();
        chk("rstmf_rsp_valid", rsp_valid, 0);
        chk("rstmf_busy", busy, 0);
        stale = 1'b0;
        for (int c = 0; c < 12; c++) begin
            nxt(); smp();
            stale |= rsp_valid | busy;
        end
        chk("rstmf_no_stale", stale, 0);
        nxt();
        req_valid = 4'hF;
        smp();
        chk("rstmf_rr_zero", req_ready, 4'b0001);
        nxt();
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
